mux8_rr_scheduler: RTL and testbench
====================================

// Module: mux8_rr_scheduler
//
// PURPOSE
//  Round-robin scheduler that shares one 8:1 CMOS transmission-gate mux between 8 requesters.
//  Drives the mux select S[2:0] and a one-hot grant back to the requesters.
//  Holds S stable for a whole grant and bounds each grant to MAX_HOLD accepted samples.
//  Inserts one dead cycle between grants so the transmission gates settle before the next select.
//
// PARAMETERS
//  MAX_HOLD  default 4  max downstream-accepted samples per grant; legal range 1..15
//
// PORTS
//  clk    input   1  single clock, rising edge
//  rst    input   1  reset, synchronous, active-high
//  req    input   8  request per mux input; req[i] asks for mux input I[i]
//  ack    input   1  downstream accepted the mux output Y this cycle
//  S      output  3  mux select, registered
//  gnt    output  8  one-hot grant, registered; all zeros when nothing is granted
//  valid  output  1  S is stable and Y carries the granted input
//
// BEHAVIOUR
//  - Reset values (first edge with rst=1): S=0, gnt=0, valid=0, ptr=0, hold cnt=0, state IDLE.
//  - State IDLE: valid=0, gnt=0, S keeps its last value.
//    - If req!=0 at an edge, winner = first set bit of req, searching from ptr upward with wrap 7->0.
//    - Same edge: S<=winner, gnt<=1<<winner, valid<=1, cnt<=0, state<=GRANT.
//    - Latency is 1 cycle: req sampled at edge k gives gnt/valid visible after edge k.
//  - State GRANT: S and gnt are frozen. req of non-granted channels is ignored.
//    - Each edge with ack=1: cnt<=cnt+1.
//    - Release when req[S]==0 at an edge.
//    - Release when ack=1 and cnt==MAX_HOLD-1 at an edge, i.e. the MAX_HOLD-th accepted sample.
//    - On release at that edge: gnt<=0, valid<=0, ptr<=(S+1) mod 8 (7 wraps to 0), state<=IDLE.
//    - Release when req[S] drops and ack=1 on the same edge: the release applies, and the ack is not counted.
//  - Gap: after a release, IDLE lasts at least 1 cycle before the next GRANT.
//    - Consecutive grants are therefore separated by exactly 1 cycle of valid=0.
//  - ack while valid=0 is ignored.
//  - With ack=0 forever, a grant holds indefinitely while req[S]=1; there is no timeout.
//  - rst=1 in any state: at the next edge all outputs and ptr return to reset values.
//    - Any in-flight grant is dropped and priority restarts at ch0.
//  - cnt width is $clog2(MAX_HOLD+1); the winner search is combinational over 8 bits.
//  - S only changes on the IDLE->GRANT edge.
//
// TESTING
//  1. rst=1 for 2 cycles with req=8'hFF -> S=0, gnt=0, valid=0 throughout.
//  2. req=8'h20 from cycle 0, ack=1 -> the next cycle shows S=5, gnt=8'h20, valid=1.
//     Released after 4 acked cycles; 1 gap cycle; S=5 again (ptr=6 wraps to find 5).
//  3. req=8'hFF, ack=1 held, MAX_HOLD=4 -> grants 0,1,...,7,0, each valid for 4 cycles.
//     Each grant is followed by 1 gap cycle, and ptr wraps 7->0.
//  4. Granted ch2 with req=8'h0C; drop req[2] after 2 acks -> valid=0 at the next edge, then gnt=8'h08, S=3.
//  5. Granted ch6, ack=0 for 20 cycles -> valid stays 1 and S=6 constant; then ack=1 x4 -> release.
//  6. rst=1 mid-grant on ch4 with req=8'h11 -> reset values next edge.
//     After rst falls, gnt=8'h01 (priority back to ch0).

Source files
------------

// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler sharing one 8:1 transmission-gate mux between 8 requesters.
// It holds the select S stable for a whole grant. Each grant ends after at most
// MAX_HOLD accepted samples. One dead cycle separates consecutive grants so the
// transmission gates can settle before the next select.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset
//   req    - per-input request, req[i] asks for mux input i
//   ack    - downstream accepted the mux output this cycle
//   S      - mux select (registered, changes only on IDLE->GRANT)
//   gnt    - one-hot grant (registered, zero when nothing granted)
//   valid  - S is stable and the mux output carries the granted input
module mux8_rr_scheduler #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       ack,
    output logic [2:0] S,
    output logic [7:0] gnt,
    output logic       valid
);

    localparam int unsigned N_CH = 8;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   s_d;
    logic [N_CH-1:0]    gnt_d;
    logic               valid_d;

    logic [SEL_W-1:0]   winner;
    logic               found;
    logic [SEL_W-1:0]   idx;

    // First set request at or above ptr. The 3-bit index wraps from 7 back to 0.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            idx = SEL_W'(ptr_q + SEL_W'(i));
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Next-state and next-output logic. All outputs are registered below.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        s_d     = S;
        gnt_d   = gnt;
        valid_d = valid;

        unique case (state_q)
            ST_IDLE: begin
                if (found) begin
                    s_d     = winner;
                    gnt_d   = N_CH'(1) << winner;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // A dropped request wins over a coincident ack, so that ack is not counted.
                if (!req[S] || (ack && (cnt_q == CNT_W'(MAX_HOLD - 1)))) begin
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    ptr_d   = SEL_W'(S + SEL_W'(1));
                    state_d = ST_IDLE;
                end else if (ack) begin
                    cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pointer, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            S       <= '0;
            gnt     <= '0;
            valid   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            S       <= s_d;
            gnt     <= gnt_d;
            valid   <= valid_d;
        end
    end

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Directed bench for mux8_rr_scheduler (MAX_HOLD = 4).
// Each check applies inputs, waits for a rising edge, and samples #1 after it.
module tb_mux8_rr_scheduler;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       ack;
    logic [2:0] S;
    logic [7:0] gnt;
    logic       valid;

    int n_checks;
    int n_fails;

    mux8_rr_scheduler #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .ack   (ack),
        .S     (S),
        .gnt   (gnt),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       ack;
        logic [2:0] exp_s;
        logic [7:0] exp_gnt;
        logic       exp_valid;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    // Drive inputs, clock once, and compare outputs just after the edge.
    task automatic step(input string name, input logic r, input logic [7:0] q, input logic a,
                        input logic [2:0] es, input logic [7:0] eg, input logic ev);
        rst = r;
        req = q;
        ack = a;
        @(posedge clk);
        #1;
        n_checks++;
        if (S !== es || gnt !== eg || valid !== ev) begin
            n_fails++;
            $display("FAIL %s: got S=%0d gnt=%02h valid=%0b, expected S=%0d gnt=%02h valid=%0b",
                     name, S, gnt, valid, es, eg, ev);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst = 1'b1;
        req = 8'h00;
        ack = 1'b0;

        // reset with requests pending; single request on ch5; drop req on ch2 mid-grant
        vecs[0]  = '{1'b1, 8'hFF, 1'b0, 3'd0, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 8'hFF, 1'b0, 3'd0, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 8'h20, 1'b1, 3'd5, 8'h20, 1'b1};
        vecs[3]  = '{1'b0, 8'h20, 1'b1, 3'd5, 8'h20, 1'b1};
        vecs[4]  = '{1'b0, 8'h20, 1'b1, 3'd5, 8'h20, 1'b1};
        vecs[5]  = '{1'b0, 8'h20, 1'b1, 3'd5, 8'h20, 1'b1};
        vecs[6]  = '{1'b0, 8'h20, 1'b1, 3'd5, 8'h00, 1'b0};
        vecs[7]  = '{1'b0, 8'h20, 1'b1, 3'd5, 8'h20, 1'b1};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 3'd5, 8'h00, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 3'd5, 8'h00, 1'b0};
        vecs[10] = '{1'b0, 8'h0C, 1'b1, 3'd2, 8'h04, 1'b1};
        vecs[11] = '{1'b0, 8'h0C, 1'b1, 3'd2, 8'h04, 1'b1};
        vecs[12] = '{1'b0, 8'h0C, 1'b1, 3'd2, 8'h04, 1'b1};
        vecs[13] = '{1'b0, 8'h08, 1'b1, 3'd2, 8'h00, 1'b0};
        vecs[14] = '{1'b0, 8'h08, 1'b0, 3'd3, 8'h08, 1'b1};
        vecs[15] = '{1'b0, 8'h00, 1'b0, 3'd3, 8'h00, 1'b0};
        vecs[16] = '{1'b0, 8'h00, 1'b0, 3'd3, 8'h00, 1'b0};

        for (int i = 0; i < NV; i++) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].req, vecs[i].ack,
                 vecs[i].exp_s, vecs[i].exp_gnt, vecs[i].exp_valid);
        end

        // All requesting with ack held: ch0..7 then ch0 again, 4 valid cycles + 1 gap each.
        step("rr_reset", 1'b1, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0);
        for (int g = 0; g < 9; g++) begin
            logic [2:0] ch;
            logic [7:0] oh;
            ch = 3'(g % 8);
            oh = 8'h01 << ch;
            for (int k = 0; k < 4; k++)
                step($sformatf("rr_g%0d_c%0d", g, k), 1'b0, 8'hFF, 1'b1, ch, oh, 1'b1);
            step($sformatf("rr_g%0d_gap", g), 1'b0, 8'hFF, 1'b1, ch, 8'h00, 1'b0);
        end
        // After the second ch0 grant the pointer is at 1; request only ch6.
        step("hold_grant", 1'b0, 8'h40, 1'b0, 3'd6, 8'h40, 1'b1);
        for (int k = 0; k < 20; k++)
            step($sformatf("hold_noack%0d", k), 1'b0, 8'h40, 1'b0, 3'd6, 8'h40, 1'b1);
        for (int k = 0; k < 3; k++)
            step($sformatf("hold_ack%0d", k), 1'b0, 8'h40, 1'b1, 3'd6, 8'h40, 1'b1);
        step("hold_release", 1'b0, 8'h40, 1'b1, 3'd6, 8'h00, 1'b0);
        step("hold_idle", 1'b0, 8'h00, 1'b0, 3'd6, 8'h00, 1'b0);

        // Pointer is at 7; ch4 wins, then ch0 joins and must be ignored until reset.
        step("rst_grant4", 1'b0, 8'h10, 1'b0, 3'd4, 8'h10, 1'b1);
        step("rst_ignore0", 1'b0, 8'h11, 1'b1, 3'd4, 8'h10, 1'b1);
        step("rst_mid", 1'b1, 8'h11, 1'b0, 3'd0, 8'h00, 1'b0);
        step("rst_prio0", 1'b0, 8'h11, 1'b0, 3'd0, 8'h01, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
